// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: per-latch write-enable/flush, PC write-enable,
// halt drain and saturating stall/flush counters for an NSTAGES-deep pipeline.
//
// state | meaning
// RUN   | normal issue; events resolved by priority each cycle
// DWAIT | data access outstanding; front of pipe frozen, bubble past MEM
// HALT  | halt drained; everything frozen until reset
module pipeline_hazard_ctrl #(
  parameter int NSTAGES    = 5,
  parameter int MEM_STAGE  = 3,
  parameter int BR_STAGE   = 3,
  parameter int REG_W      = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               mem_dREN,
  input  logic               mem_dWEN,
  input  logic               mem_halt,
  input  logic               br_taken,
  input  logic               id_jump,
  input  logic               ex_memread,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rt,
  output logic               pc_wen,
  output logic [NSTAGES-2:0] lat_wen,
  output logic [NSTAGES-2:0] lat_flush,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_events
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LU_LOAD = 3'(LU_BUBBLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic data_stall;
  logic lu_new;
  logic count_flush;

  assign data_stall = (mem_dREN | mem_dWEN) & ~dhit;
  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign lu_new = ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_wen      = ihit;
    lat_wen     = '1;
    lat_flush   = '0;
    halted      = 1'b0;
    count_flush = 1'b0;

    if (RST) begin
      pc_wen    = 1'b0;
      lat_flush = '1;
      state_d   = RUN;
      lu_cnt_d  = '0;
      stall_d   = '0;
      flush_d   = '0;
    end else begin
      if (state_q == HALT) begin
        pc_wen  = 1'b0;
        lat_wen = '0;
        halted  = 1'b1;
      end else if (data_stall) begin
        state_d = DWAIT;
        pc_wen  = 1'b0;
        for (int k = 0; k < MEM_STAGE; k++) lat_wen[k] = 1'b0;
        lat_flush[MEM_STAGE] = 1'b1;
      end else if (mem_halt) begin
        state_d = HALT;
        pc_wen  = 1'b0;
        for (int k = 0; k < MEM_STAGE; k++) lat_flush[k] = 1'b1;
      end else if (br_taken) begin
        state_d     = RUN;
        pc_wen      = 1'b1;
        lu_cnt_d    = '0;
        count_flush = 1'b1;
        for (int k = 0; k < BR_STAGE; k++) lat_flush[k] = 1'b1;
      end else if (lu_new || (lu_cnt_q != '0)) begin
        state_d      = RUN;
        pc_wen       = 1'b0;
        lat_wen[0]   = 1'b0;
        lat_flush[1] = 1'b1;
        if (lu_new && (lu_cnt_q == '0)) lu_cnt_d = LU_LOAD;
        else if (lu_cnt_q != '0)        lu_cnt_d = lu_cnt_q - 3'd1;
      end else if (id_jump) begin
        state_d      = RUN;
        lat_flush[0] = 1'b1;
        count_flush  = 1'b1;
      end else if (!ihit) begin
        state_d      = RUN;
        lat_flush[0] = 1'b1;
      end else begin
        state_d = RUN;
      end

      if (!pc_wen && (state_q != HALT) && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
      if (count_flush && (flush_q != '1))                  flush_d = flush_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    lu_cnt_q <= lu_cnt_d;
    stall_q  <= stall_d;
    flush_q  <= flush_d;
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, ihit, dhit, mem_dren, mem_dwen, mem_halt, br_taken, id_jump;
  logic       ex_memread, id_uses_rt;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic       pc_wen, halted;
  logic [3:0] lat_wen, lat_flush, stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .NSTAGES(5), .MEM_STAGE(3), .BR_STAGE(3), .REG_W(5), .LU_BUBBLES(2), .CNT_W(4)
  ) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dren),
    .mem_dWEN(mem_dwen), .mem_halt(mem_halt), .br_taken(br_taken), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .pc_wen(pc_wen), .lat_wen(lat_wen), .lat_flush(lat_flush),
    .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic       pc;
    logic [3:0] wen;
    logic [3:0] fl;
    logic       h;
    logic [3:0] st;
    logic [3:0] fe;
  } exp_t;

  typedef struct packed {
    logic       rst, ihit, dhit, dren, dwen, mhalt, br, jump, memread, uses_rt;
    logic [4:0] exrd, rs, rt;
  } stim_t;

  exp_t  exp_q[$];
  string name_q[$];
  stim_t nx;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic idle();
    nx = '0;
    nx.ihit = 1'b1;
    nx.dhit = 1'b1;
  endtask

  task automatic apply(input string nm, input logic pc, input logic [3:0] wen, fl,
                       input logic h, input logic [3:0] st, fe, input bit push = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst = nx.rst; ihit = nx.ihit; dhit = nx.dhit; mem_dren = nx.dren; mem_dwen = nx.dwen;
    mem_halt = nx.mhalt; br_taken = nx.br; id_jump = nx.jump; ex_memread = nx.memread;
    id_uses_rt = nx.uses_rt; ex_rd = nx.exrd; id_rs = nx.rs; id_rt = nx.rt;
    if (push) begin
      e = '{pc: pc, wen: wen, fl: fl, h: h, st: st, fe: fe};
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{pc: pc_wen, wen: lat_wen, fl: lat_flush, h: halted, st: stall_cycles, fe: flush_events};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%b wen=%b fl=%b halt=%b st=%0d fe=%0d, want pc=%b wen=%b fl=%b halt=%b st=%0d fe=%0d",
                 nm, a.pc, a.wen, a.fl, a.h, a.st, a.fe, e.pc, e.wen, e.fl, e.h, e.st, e.fe);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
    br_taken = 1'b0; id_jump = 1'b0; ex_memread = 1'b0; id_uses_rt = 1'b0;
    ex_rd = '0; id_rs = '0; id_rt = '0;

    idle(); nx.rst = 1'b1;
    apply("rst0", 0, 4'hF, 4'hF, 0, 0, 0, 1'b0);
    apply("rst_state", 0, 4'hF, 4'hF, 0, 0, 0);
    idle();
    apply("run_default", 1, 4'hF, 4'h0, 0, 0, 0);

    // reset in the middle of a data wait
    for (int i = 0; i < 3; i++) begin
      idle(); nx.dren = 1'b1; nx.dhit = 1'b0;
      apply("dwait_pre_rst", 0, 4'b1000, 4'b1000, 0, 4'(i), 0);
    end
    idle(); nx.rst = 1'b1; nx.dren = 1'b1; nx.dhit = 1'b0;
    apply("rst_mid_dwait", 0, 4'hF, 4'hF, 0, 3, 0);
    idle();
    apply("after_rst_run", 1, 4'hF, 4'h0, 0, 0, 0);

    // load-use on rs: two bubbles
    idle(); nx.memread = 1'b1; nx.exrd = 5'd8; nx.rs = 5'd8;
    apply("lu_rs_1", 0, 4'b1110, 4'b0010, 0, 0, 0);
    idle();
    apply("lu_rs_2", 0, 4'b1110, 4'b0010, 0, 1, 0);
    idle();
    apply("lu_rs_done", 1, 4'hF, 4'h0, 0, 2, 0);
    idle(); nx.memread = 1'b1; nx.exrd = 5'd0; nx.rs = 5'd0;
    apply("lu_r0", 1, 4'hF, 4'h0, 0, 2, 0);
    idle();
    apply("lu_r0_next", 1, 4'hF, 4'h0, 0, 2, 0);

    // load-use on rt only when rt is read
    idle(); nx.memread = 1'b1; nx.exrd = 5'd5; nx.rt = 5'd5; nx.rs = 5'd1;
    apply("lu_rt_unused", 1, 4'hF, 4'h0, 0, 2, 0);
    idle(); nx.memread = 1'b1; nx.exrd = 5'd5; nx.rt = 5'd5; nx.rs = 5'd1; nx.uses_rt = 1'b1;
    apply("lu_rt_1", 0, 4'b1110, 4'b0010, 0, 2, 0);
    idle();
    apply("lu_rt_2", 0, 4'b1110, 4'b0010, 0, 3, 0);
    idle();
    apply("lu_rt_done", 1, 4'hF, 4'h0, 0, 4, 0);

    idle(); nx.rst = 1'b1;
    apply("rst_b", 0, 4'hF, 4'hF, 0, 4, 0);

    // store miss for 4 cycles
    for (int i = 0; i < 4; i++) begin
      idle(); nx.dwen = 1'b1; nx.dhit = 1'b0;
      apply("dmiss", 0, 4'b1000, 4'b1000, 0, 4'(i), 0);
    end
    idle(); nx.dwen = 1'b1;
    apply("dmiss_hit", 1, 4'hF, 4'h0, 0, 4, 0);

    // branch takes priority over a load-use hazard and clears the bubble counter
    idle(); nx.br = 1'b1; nx.memread = 1'b1; nx.exrd = 5'd8; nx.rs = 5'd8;
    apply("br_over_lu", 1, 4'hF, 4'b0111, 0, 4, 0);
    idle();
    apply("br_after", 1, 4'hF, 4'h0, 0, 4, 1);

    // data stall outranks a taken branch
    idle(); nx.dren = 1'b1; nx.dhit = 1'b0; nx.br = 1'b1;
    apply("dstall_over_br", 0, 4'b1000, 4'b1000, 0, 4, 1);

    idle(); nx.jump = 1'b1;
    apply("jump", 1, 4'hF, 4'b0001, 0, 5, 1);
    idle(); nx.jump = 1'b1; nx.ihit = 1'b0;
    apply("jump_nohit", 0, 4'hF, 4'b0001, 0, 5, 2);
    idle(); nx.ihit = 1'b0;
    apply("imiss", 0, 4'hF, 4'b0001, 0, 6, 3);
    idle();
    apply("imiss_after", 1, 4'hF, 4'h0, 0, 7, 3);

    // halt drain, then frozen regardless of inputs
    idle(); nx.mhalt = 1'b1;
    apply("halt_req", 0, 4'hF, 4'b0111, 0, 7, 3);
    for (int i = 0; i < 10; i++) begin
      idle(); nx.ihit = i[0]; nx.br = ~i[0]; nx.dren = (i == 3); nx.dhit = (i != 3);
      apply("halted", 0, 4'h0, 4'h0, 1, 8, 3);
    end
    idle(); nx.rst = 1'b1;
    apply("rst_halt", 0, 4'hF, 4'hF, 0, 8, 3);
    idle();
    apply("post_halt_run", 1, 4'hF, 4'h0, 0, 0, 0);

    // stall counter saturation
    for (int i = 0; i < 20; i++) begin
      idle(); nx.ihit = 1'b0;
      apply("sat", 0, 4'hF, 4'b0001, 0, (i > 15) ? 4'd15 : 4'(i), 0);
    end
    idle();
    apply("sat_hold", 1, 4'hF, 4'h0, 0, 15, 0);

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
